// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and constants for the store buffer
package store_buffer_pkg;

  localparam int WORD_OFFSET_BITS = 2;
  localparam int BYTE_LANES       = 4;
  localparam int DATA_W           = 32;
  // Entries carry word addresses wide enough for any AW up to MAX_AW.
  localparam int MAX_AW           = 64;
  localparam int WA_W             = MAX_AW - WORD_OFFSET_BITS;

  typedef struct packed {
    logic [WA_W-1:0]       word_addr;
    logic [DATA_W-1:0]     data;
    logic [BYTE_LANES-1:0] we;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// rtl/store_buffer_fwd.sv - youngest-first byte-lane store-to-load forwarding mux
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t              i_entries [DEPTH],
  input  logic [DEPTH-1:0]       i_valid,
  input  logic [PW-1:0]          i_head,
  input  logic [WA_W-1:0]        i_ld_word,
  output logic [DATA_W-1:0]      o_ld_data,
  output logic [BYTE_LANES-1:0]  o_ld_mask
);

  // Walk oldest to youngest so younger matches overwrite older ones.
  always_comb begin : fwd_walk
    logic [PW-1:0] v_idx;
    o_ld_data = '0;
    o_ld_mask = '0;
    v_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_idx = i_head + PW'(i);
      if (i_valid[v_idx] && (i_entries[v_idx].word_addr == i_ld_word)) begin
        for (int l = 0; l < BYTE_LANES; l++) begin
          if (i_entries[v_idx].we[l]) begin
            o_ld_data[l*8 +: 8] = i_entries[v_idx].data[l*8 +: 8];
            o_ld_mask[l]        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue with byte forwarding to loads
// Optional store coalescing into the youngest entry: STORE_BUFFER_COALESCE_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [AW-1:0]         push_addr,
  input  logic [31:0]           push_data,
  input  logic [3:0]            push_we,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [AW-1:0]         mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_we,
  input  logic [AW-1:0]         ld_addr,
  output logic [31:0]           ld_data,
  output logic [3:0]            ld_mask,
  output logic                  ld_hit,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        r_entries [DEPTH];
  logic [PW:0]      r_head;
  logic [PW:0]      r_tail;

  logic [PW:0]      w_count;
  logic             w_full;
  logic             w_empty;
  logic [PW-1:0]    w_head_idx;
  logic [PW-1:0]    w_tail_idx;
  logic [PW-1:0]    w_young_idx;
  logic [DEPTH-1:0] w_valid;
  logic [WA_W-1:0]  w_push_wa;
  logic [WA_W-1:0]  w_ld_wa;
  logic             w_push;
  logic             w_pop;
  logic             w_merge;
  logic             w_alloc;
  logic             w_unused_addr_bits;

  assign w_head_idx  = r_head[PW-1:0];
  assign w_tail_idx  = r_tail[PW-1:0];
  assign w_young_idx = w_tail_idx - PW'(1);
  assign w_count     = r_tail - r_head;
  assign w_empty     = (r_head == r_tail);
  assign w_full      = (w_head_idx == w_tail_idx) && (r_head[PW] != r_tail[PW]);

  assign w_push_wa   = WA_W'(push_addr[AW-1:WORD_OFFSET_BITS]);
  assign w_ld_wa     = WA_W'(ld_addr[AW-1:WORD_OFFSET_BITS]);
  assign w_unused_addr_bits = ^{push_addr[WORD_OFFSET_BITS-1:0], ld_addr[WORD_OFFSET_BITS-1:0]};

  assign push_ready  = !w_full;
  assign mem_valid   = !w_empty;
  assign w_push      = push_valid && push_ready;
  assign w_pop       = mem_valid && mem_ready;

`ifdef STORE_BUFFER_COALESCE_EN
  // The youngest entry cannot absorb a store if it is leaving this cycle.
  assign w_merge = w_push && (push_we != '0) && !w_empty
                && (r_entries[w_young_idx].word_addr == w_push_wa)
                && !((w_count == (PW+1)'(1)) && w_pop);
`else
  assign w_merge = 1'b0;
`endif
  assign w_alloc = w_push && (push_we != '0) && !w_merge;

  // Slot i is live when its distance from head is below occupancy.
  always_comb begin : valid_vec
    logic [PW-1:0] v_off;
    v_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_off      = PW'(i) - w_head_idx;
      w_valid[i] = ({1'b0, v_off} < w_count);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else begin
      if (w_pop) r_head <= r_head + (PW+1)'(1);
      if (w_alloc) begin
        r_entries[w_tail_idx].word_addr <= w_push_wa;
        r_entries[w_tail_idx].data      <= push_data;
        r_entries[w_tail_idx].we        <= push_we;
        r_tail <= r_tail + (PW+1)'(1);
      end
      if (w_merge) begin
        for (int l = 0; l < BYTE_LANES; l++) begin
          if (push_we[l]) r_entries[w_young_idx].data[l*8 +: 8] <= push_data[l*8 +: 8];
        end
        r_entries[w_young_idx].we <= r_entries[w_young_idx].we | push_we;
      end
    end
  end

  assign mem_addr = {r_entries[w_head_idx].word_addr[AW-WORD_OFFSET_BITS-1:0],
                     {WORD_OFFSET_BITS{1'b0}}};
  assign mem_din  = r_entries[w_head_idx].data;
  assign mem_we   = r_entries[w_head_idx].we;
  assign empty    = w_empty;
  assign count    = w_count;
  assign ld_hit   = |ld_mask;

  store_buffer_fwd #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .i_entries (r_entries),
    .i_valid   (w_valid),
    .i_head    (w_head_idx),
    .i_ld_word (w_ld_wa),
    .o_ld_data (ld_data),
    .o_ld_mask (ld_mask)
  );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic [3:0]  push_we;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_mask;
  logic        ld_hit;
  logic        empty;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data), .push_we(push_we),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_mask(ld_mask), .ld_hit(ld_hit),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    push_valid = 1'b1; push_addr = a; push_data = d; push_we = we;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic drain();
    mem_ready = 1'b1;
    repeat (6) tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%0b exp=0", mem_valid); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready got=%0b exp=1", push_ready); end
    total++; if (ld_mask !== 4'b0000) begin bad++; $display("FAIL reset_ld_mask got=%b exp=0000", ld_mask); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_drain();
    mem_ready = 1'b0;
    do_push(32'h1000, 32'hDEADBEEF, 4'b1111);
    do_push(32'h1004, 32'h000000AA, 4'b0001);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", count); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0b exp=0", empty); end
    tick();
    total++; if (mem_valid !== 1'b1 || mem_addr !== 32'h1000 || mem_din !== 32'hDEADBEEF || mem_we !== 4'b1111)
      begin bad++; $display("FAIL basic_head0 got=%0b/%h/%h/%b exp=1/00001000/deadbeef/1111", mem_valid, mem_addr, mem_din, mem_we); end
    mem_ready = 1'b1;
    tick();
    total++; if (mem_addr !== 32'h1004 || mem_din !== 32'h000000AA || mem_we !== 4'b0001)
      begin bad++; $display("FAIL basic_head1 got=%h/%h/%b exp=00001004/000000aa/0001", mem_addr, mem_din, mem_we); end
    tick();
    mem_ready = 1'b0;
    total++; if (empty !== 1'b1 || mem_valid !== 1'b0) begin bad++; $display("FAIL basic_end_empty got=%0b/%0b exp=1/0", empty, mem_valid); end
  endtask

  task automatic test_full();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_push(32'h100 + 32'(i*4), 32'(i+1), 4'b1111);
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL full_push_ready got=%0b exp=0", push_ready); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
    do_push(32'h200, 32'h55, 4'b1111);
    total++; if (count !== 3'd4 || mem_din !== 32'd1) begin bad++; $display("FAIL full_held_off got=%0d/%h exp=4/00000001", count, mem_din); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    total++; if (push_ready !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL full_after_pop got=%0b/%0d exp=1/3", push_ready, count); end
    mem_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      total++; if (mem_din !== 32'(i)) begin bad++; $display("FAIL full_order got=%h exp=%h", mem_din, 32'(i)); end
      tick();
    end
    mem_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%0b exp=1", empty); end
  endtask

  task automatic test_forward();
    mem_ready = 1'b0;
    do_push(32'h2000, 32'h11223344, 4'b1111);
    do_push(32'h2000, 32'h0000AB00, 4'b0010);
    ld_addr = 32'h2002;
    #1;
    total++; if (ld_mask !== 4'b1111 || ld_data !== 32'h1122AB44 || ld_hit !== 1'b1)
      begin bad++; $display("FAIL fwd_youngest got=%b/%h/%0b exp=1111/1122ab44/1", ld_mask, ld_data, ld_hit); end
    mem_ready = 1'b1;
    #1;
    total++; if (ld_mask !== 4'b1111) begin bad++; $display("FAIL fwd_while_pop got=%b exp=1111", ld_mask); end
    mem_ready = 1'b0;
    push_valid = 1'b1; push_addr = 32'h2800; push_data = 32'h99999999; push_we = 4'b1111;
    ld_addr = 32'h2800;
    #1;
    total++; if (ld_mask !== 4'b0000) begin bad++; $display("FAIL fwd_same_cycle_push got=%b exp=0000", ld_mask); end
    push_valid = 1'b0;
    drain();
  endtask

  task automatic test_miss_we0();
    mem_ready = 1'b0;
    do_push(32'h3004, 32'h12345678, 4'b1111);
    ld_addr = 32'h3000;
    #1;
    total++; if (ld_mask !== 4'b0000 || ld_hit !== 1'b0) begin bad++; $display("FAIL miss_mask got=%b/%0b exp=0000/0", ld_mask, ld_hit); end
    do_push(32'h3000, 32'hFFFFFFFF, 4'b0000);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL we0_count got=%0d exp=1", count); end
    total++; if (ld_mask !== 4'b0000) begin bad++; $display("FAIL we0_no_fwd got=%b exp=0000", ld_mask); end
    drain();
  endtask

  task automatic test_push_pop_full();
    logic [31:0] exp_q[$];
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_push(32'h5000 + 32'(i*4), 32'hA0 + 32'(i), 4'b1111);
    mem_ready = 1'b1;
    push_valid = 1'b1; push_addr = 32'h6000; push_data = 32'hB0; push_we = 4'b1111;
    tick();
    total++; if (count !== 3'd3 || mem_din !== 32'hA1) begin bad++; $display("FAIL ppf_first got=%0d/%h exp=3/000000a1", count, mem_din); end
    tick();
    total++; if (count !== 3'd3 || mem_din !== 32'hA2) begin bad++; $display("FAIL ppf_second got=%0d/%h exp=3/000000a2", count, mem_din); end
    exp_q = '{32'hA2, 32'hA3, 32'hB0};
    for (int k = 0; k < 10; k++) begin
      push_addr = 32'h7000 + 32'(k*4); push_data = 32'hC0 + 32'(k);
      total++; if (mem_din !== exp_q[0] || push_ready !== 1'b1)
        begin bad++; $display("FAIL ppf_stream k=%0d got=%h/%0b exp=%h/1", k, mem_din, push_ready, exp_q[0]); end
      void'(exp_q.pop_front());
      exp_q.push_back(32'hC0 + 32'(k));
      tick();
    end
    push_valid = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL ppf_count got=%0d exp=3", count); end
    for (int k = 0; k < 3; k++) begin
      total++; if (mem_din !== exp_q[0]) begin bad++; $display("FAIL ppf_tail k=%0d got=%h exp=%h", k, mem_din, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    mem_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ppf_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_coalesce();
    mem_ready = 1'b0;
    do_push(32'h4000, 32'h000000CC, 4'b0001);
    do_push(32'h4001, 32'h0000DD00, 4'b0010);
`ifdef STORE_BUFFER_COALESCE_EN
    total++; if (count !== 3'd1 || mem_din !== 32'h0000DDCC || mem_we !== 4'b0011)
      begin bad++; $display("FAIL coalesce_on got=%0d/%h/%b exp=1/0000ddcc/0011", count, mem_din, mem_we); end
`else
    total++; if (count !== 3'd2 || mem_din !== 32'h000000CC || mem_we !== 4'b0001)
      begin bad++; $display("FAIL coalesce_off got=%0d/%h/%b exp=2/000000cc/0001", count, mem_din, mem_we); end
`endif
    drain();
  endtask

  task automatic test_async_reset();
    mem_ready = 1'b0;
    do_push(32'h8000, 32'h1, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (mem_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL async_reset got=%0b/%0d exp=0/0", mem_valid, count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL async_reset_after got=%0b exp=1", empty); end
  endtask

  initial begin
    push_valid = 1'b0; push_addr = '0; push_data = '0; push_we = '0;
    mem_ready = 1'b0; ld_addr = '0; rst_n = 1'b0;
    test_reset();
    test_basic_drain();
    test_full();
    test_forward();
    test_miss_we0();
    test_push_pop_full();
    test_coalesce();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
